// File: rtl/fifo_wr_arb.sv
// Two-requester write-port arbiter with credit tracking for the shared FIFO push port.
// Define FIFO_WR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module fifo_wr_arb #(
   parameter int DW = 4,
   parameter int AW = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req0_i,
   input  logic [DW-1:0] dat0_i,
   output logic          rdy0_o,
   input  logic          req1_i,
   input  logic [DW-1:0] dat1_i,
   output logic          rdy1_o,
   input  logic          credit_ret_i,
   output logic          wr_en_o,
   output logic [DW-1:0] wr_dat_o,
   output logic          wr_src_o,
   output logic [AW:0]   credits_o,
   output logic [7:0]    cnt0_o,
   output logic [7:0]    cnt1_o,
   output logic          ovf_o
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] CRED_MAX = DEPTH[AW:0];

   logic [AW:0] credits_q;
   logic        ok;
   logic        pref;
   logic        grant0;
   logic        grant1;
   logic        xfer;

   assign ok = (credits_q != '0);

   // Handshake: reqX_i is valid, rdyX_o is ready; a transfer happens in any
   // cycle where both are high. rdyX_o never depends on credit_ret_i, so a
   // returned slot only enables a grant from the following cycle.
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
   assign pref = 1'b0;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst_i && ok) begin
         grant0 = req0_i;
         grant1 = req1_i & ~req0_i;
      end
   end
`else
   logic pref_q;

   assign pref = pref_q;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst_i && ok) begin
         grant0 = req0_i & (~req1_i | ~pref);
         grant1 = req1_i & (~req0_i | pref);
      end
   end

   // Preference flips to the other requester after each transfer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pref_q <= 1'b0;
      end else if (grant0) begin
         pref_q <= 1'b1;
      end else if (grant1) begin
         pref_q <= 1'b0;
      end
   end
`endif

   assign rdy0_o = grant0;
   assign rdy1_o = grant1;
   assign xfer   = grant0 | grant1;

   // Registered push stage; data and source hold when no transfer occurs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_en_o  <= 1'b0;
         wr_dat_o <= '0;
         wr_src_o <= 1'b0;
      end else begin
         wr_en_o <= xfer;
         if (grant0) begin
            wr_dat_o <= dat0_i;
            wr_src_o <= 1'b0;
         end else if (grant1) begin
            wr_dat_o <= dat1_i;
            wr_src_o <= 1'b1;
         end
      end
   end

   // A return with no push at full credit is dropped and flagged sticky.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         credits_q <= CRED_MAX;
         ovf_o     <= 1'b0;
      end else begin
         if (xfer && !credit_ret_i) begin
            credits_q <= credits_q - (AW+1)'(1);
         end else if (!xfer && credit_ret_i) begin
            if (credits_q == CRED_MAX) begin
               ovf_o <= 1'b1;
            end else begin
               credits_q <= credits_q + (AW+1)'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt0_o <= 8'd0;
         cnt1_o <= 8'd0;
      end else begin
         if (grant0) cnt0_o <= cnt0_o + 8'd1;
         if (grant1) cnt1_o <= cnt1_o + 8'd1;
      end
   end

   assign credits_o = credits_q;

   // pref is only observed by the grant logic; tie it off for the fixed-priority build.
   logic unused_pref;
   assign unused_pref = pref;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: reset, fill, credit return, contention, overflow, mid-op reset.
module tb_fifo_wr_arb;

   localparam int DW = 4;
   localparam int AW = 2;

   logic          clk;
   logic          rst;
   logic          req0;
   logic [DW-1:0] dat0;
   logic          rdy0;
   logic          req1;
   logic [DW-1:0] dat1;
   logic          rdy1;
   logic          credit_ret;
   logic          wr_en;
   logic [DW-1:0] wr_dat;
   logic          wr_src;
   logic [AW:0]   credits;
   logic [7:0]    cnt0;
   logic [7:0]    cnt1;
   logic          ovf;

   int            n_vec;
   int            n_err;
   logic [DW-1:0] exp_q[$];

   fifo_wr_arb #(.DW(DW), .AW(AW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req0_i       (req0),
      .dat0_i       (dat0),
      .rdy0_o       (rdy0),
      .req1_i       (req1),
      .dat1_i       (dat1),
      .rdy1_o       (rdy1),
      .credit_ret_i (credit_ret),
      .wr_en_o      (wr_en),
      .wr_dat_o     (wr_dat),
      .wr_src_o     (wr_src),
      .credits_o    (credits),
      .cnt0_o       (cnt0),
      .cnt1_o       (cnt1),
      .ovf_o        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic [DW-1:0] d0,
                        input logic r1, input logic [DW-1:0] d1, input logic ret);
      req0       = r0;
      dat0       = d0;
      req1       = r1;
      dat1       = d1;
      credit_ret = ret;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_push(input string tag, input logic src);
      logic [DW-1:0] e;
      check({tag, "_wr_en"}, 32'(wr_en), 32'(1));
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'(1));
      end else begin
         e = exp_q.pop_front();
         check({tag, "_wr_dat"}, 32'(wr_dat), 32'(e));
      end
      check({tag, "_wr_src"}, 32'(wr_src), 32'(src));
   endtask

   initial begin
      logic exp_src;
      n_vec = 0;
      n_err = 0;

      // Reset with both requests asserted.
      rst = 1'b1;
      drive(1'b1, 4'h0, 1'b1, 4'h0, 1'b0);
      #1;
      check("rst_rdy0", 32'(rdy0), 32'(0));
      check("rst_rdy1", 32'(rdy1), 32'(0));
      tick();
      tick();
      check("rst_rdy0_b", 32'(rdy0), 32'(0));
      check("rst_rdy1_b", 32'(rdy1), 32'(0));
      check("rst_wr_en", 32'(wr_en), 32'(0));
      check("rst_wr_dat", 32'(wr_dat), 32'(0));
      check("rst_wr_src", 32'(wr_src), 32'(0));
      check("rst_credits", 32'(credits), 32'(4));
      check("rst_cnt0", 32'(cnt0), 32'(0));
      check("rst_cnt1", 32'(cnt1), 32'(0));
      check("rst_ovf", 32'(ovf), 32'(0));
      rst = 1'b0;

      // Fill from requester 0 until credits run out.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 4'(i), 1'b0, 4'h0, 1'b0);
         #1;
         check("fill_rdy0", 32'(rdy0), 32'(1));
         exp_q.push_back(4'(i));
         tick();
         expect_push("fill", 1'b0);
         check("fill_credits", 32'(credits), 32'(4 - i));
      end
      drive(1'b1, 4'h5, 1'b0, 4'h0, 1'b0);
      #1;
      check("empty_rdy0", 32'(rdy0), 32'(0));
      tick();
      check("empty_wr_en", 32'(wr_en), 32'(0));
      check("empty_wr_dat_hold", 32'(wr_dat), 32'(4));
      drive(1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
      #1;
      check("ret_same_cycle_rdy0", 32'(rdy0), 32'(0));
      tick();
      check("ret_credits", 32'(credits), 32'(1));
      drive(1'b1, 4'h5, 1'b0, 4'h0, 1'b0);
      #1;
      check("ret_rdy0", 32'(rdy0), 32'(1));
      exp_q.push_back(4'h5);
      tick();
      expect_push("fill5", 1'b0);
      check("fill5_credits", 32'(credits), 32'(0));
      check("fill5_cnt0", 32'(cnt0), 32'(5));

      // Simultaneous push and return at one credit.
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      tick();
      check("sim_credits_pre", 32'(credits), 32'(1));
      drive(1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
      #1;
      check("sim_rdy1", 32'(rdy1), 32'(1));
      check("sim_rdy0", 32'(rdy0), 32'(0));
      exp_q.push_back(4'h9);
      tick();
      expect_push("sim", 1'b1);
      check("sim_credits", 32'(credits), 32'(1));
      check("sim_cnt1", 32'(cnt1), 32'(1));

      // Contention with a return every cycle.
      for (int k = 0; k < 4; k++) begin
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
         exp_src = 1'b0;
`else
         exp_src = (k % 2) == 1;
`endif
         drive(1'b1, 4'(10 + k), 1'b1, 4'(k), 1'b1);
         #1;
         check("cont_rdy0", 32'(rdy0), 32'(!exp_src));
         check("cont_rdy1", 32'(rdy1), 32'(exp_src));
         exp_q.push_back(exp_src ? 4'(k) : 4'(10 + k));
         tick();
         expect_push("cont", exp_src);
         check("cont_credits", 32'(credits), 32'(1));
      end
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
      check("cont_cnt0", 32'(cnt0), 32'(9));
      check("cont_cnt1", 32'(cnt1), 32'(1));
`else
      check("cont_cnt0", 32'(cnt0), 32'(7));
      check("cont_cnt1", 32'(cnt1), 32'(3));
`endif

      // Return credits back to full, then overflow.
      for (int j = 2; j <= 4; j++) begin
         drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
         tick();
         check("refill_credits", 32'(credits), 32'(j));
         check("refill_wr_en", 32'(wr_en), 32'(0));
      end
      check("pre_ovf", 32'(ovf), 32'(0));
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      tick();
      check("ovf_credits", 32'(credits), 32'(4));
      check("ovf_flag", 32'(ovf), 32'(1));
      drive(1'b1, 4'h3, 1'b0, 4'h0, 1'b0);
      #1;
      exp_q.push_back(4'h3);
      tick();
      expect_push("post_ovf", 1'b0);
      check("post_ovf_credits", 32'(credits), 32'(3));
      check("ovf_sticky", 32'(ovf), 32'(1));

      // Reset while a push is staged.
      check("midrst_pre_wr_en", 32'(wr_en), 32'(1));
      rst = 1'b1;
      drive(1'b1, 4'h7, 1'b1, 4'h7, 1'b0);
      #1;
      check("midrst_rdy0", 32'(rdy0), 32'(0));
      check("midrst_rdy1", 32'(rdy1), 32'(0));
      tick();
      check("midrst_wr_en", 32'(wr_en), 32'(0));
      check("midrst_credits", 32'(credits), 32'(4));
      check("midrst_wr_src", 32'(wr_src), 32'(0));
      check("midrst_ovf", 32'(ovf), 32'(0));
      check("midrst_cnt0", 32'(cnt0), 32'(0));
      rst = 1'b0;
      #1;
      check("post_rst_rdy0", 32'(rdy0), 32'(1));
      check("post_rst_rdy1", 32'(rdy1), 32'(0));
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick();
      check("exp_q_drained", 32'(exp_q.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
